// File: rtl/ps2_rx_fifo_if.sv
// ps2_rx_fifo_if: bus between the PS/2 line/host side and the ps2_rx_fifo receiver.
//  master : drives ps2c, ps2d, rd_en; observes the FIFO head, flags and event pulses
//  slave  : the receiver; outputs dato, fifo_empty, fifo_full, fifo_count and pulses
interface ps2_rx_fifo_if #(
    parameter int FIFO_AW = 3
);
    logic             ps2c;
    logic             ps2d;
    logic             rd_en;
    logic [7:0]       dato;
    logic             fifo_empty;
    logic             fifo_full;
    logic [FIFO_AW:0] fifo_count;
    logic             rx_done_tick;
    logic             parity_err;
    logic             frame_err;
    logic             timeout_err;
    logic             overflow;
    modport master (
        output ps2c, ps2d, rd_en,
        input  dato, fifo_empty, fifo_full, fifo_count,
        input  rx_done_tick, parity_err, frame_err, timeout_err, overflow
    );
    modport slave (
        input  ps2c, ps2d, rd_en,
        output dato, fifo_empty, fifo_full, fifo_count,
        output rx_done_tick, parity_err, frame_err, timeout_err, overflow
    );
endinterface

// File: rtl/ps2_rx_fifo.sv
// ps2_rx_fifo: PS/2 device-to-host receiver with glitch filter, frame checks and byte FIFO.
//  clk_nexys : system clock
//  reset     : asynchronous, active-high reset
//  bus       : ps2_rx_fifo_if.slave
//              in  ps2c, ps2d (raw PS/2 lines), rd_en (pop FIFO head)
//              out dato (FWFT head), fifo_empty, fifo_full, fifo_count,
//                  rx_done_tick, parity_err, frame_err, timeout_err, overflow (1-cycle pulses)
module ps2_rx_fifo #(
    parameter int FILTER_LEN  = 8,
    parameter int TIMEOUT_CYC = 100000,
    parameter int FIFO_AW     = 3
) (
    input logic          clk_nexys,
    input logic          reset,
    ps2_rx_fifo_if.slave bus
);
    localparam int DEPTH = 2 ** FIFO_AW;
    localparam int TW = $clog2(TIMEOUT_CYC) + 1;
    localparam logic [TW-1:0] T_LAST = TW'(TIMEOUT_CYC - 1);
    localparam logic [FIFO_AW:0] CNT_FULL = (FIFO_AW + 1)'(DEPTH);
    localparam logic [1:0] IDLE = 2'd0, DATA = 2'd1, CHECK = 2'd2;

    logic [FILTER_LEN-1:0] filt_reg;
    logic                  f_ps2c, f_ps2c_next, fall;
    logic [1:0]            d_sync;
    logic                  d;
    logic [1:0]            state;
    logic [3:0]            n;
    logic [TW-1:0]         tcnt;
    logic [10:0]           sr;
    logic                  p, good, push, pop;
    logic [7:0]            mem [DEPTH];
    logic [FIFO_AW-1:0]    wr_ptr, rd_ptr;
    logic [FIFO_AW:0]      count, cnt_next;
    logic                  empty_r, full_r;
    logic                  rx_r, par_r, frm_r, to_r, ovf_r;

    // Filtered clock only changes on a full run of equal samples, otherwise holds.
    always_comb begin
        f_ps2c_next = &filt_reg ? 1'b1 : ~|filt_reg ? 1'b0 : f_ps2c;
        fall        = f_ps2c & ~f_ps2c_next;
        d           = d_sync[1];
    end

    // ps2d is synchronised; the filter delay on ps2c keeps it aligned with the data window.
    always_ff @(posedge clk_nexys or posedge reset) begin
        if (reset) begin
            filt_reg <= '0;
            f_ps2c   <= 1'b0;
            d_sync   <= 2'b00;
        end else begin
            filt_reg <= {bus.ps2c, filt_reg[FILTER_LEN-1:1]};
            f_ps2c   <= f_ps2c_next;
            d_sync   <= {d_sync[0], bus.ps2d};
        end
    end

    // Frame layout after the last shift: sr[10]=stop, sr[9]=parity, sr[8:1]=data, sr[0]=start.
    always_comb begin
        p        = ^sr[9:1];
        good     = (state == CHECK) & p & sr[10] & ~sr[0];
        pop      = bus.rd_en & ~empty_r;
        push     = good & (~full_r | pop);
        cnt_next = (push & ~pop) ? count + 1'b1 : (pop & ~push) ? count - 1'b1 : count;
    end

    always_ff @(posedge clk_nexys or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            n     <= '0;
            tcnt  <= '0;
            sr    <= '0;
            rx_r  <= 1'b0;
            par_r <= 1'b0;
            frm_r <= 1'b0;
            to_r  <= 1'b0;
            ovf_r <= 1'b0;
        end else begin
            rx_r  <= 1'b0;
            par_r <= 1'b0;
            frm_r <= 1'b0;
            to_r  <= 1'b0;
            ovf_r <= 1'b0;
            case (state)
                IDLE: begin
                    if (fall && !d) begin
                        sr    <= {d, sr[10:1]};
                        n     <= 4'd9;
                        tcnt  <= '0;
                        state <= DATA;
                    end
                end
                DATA: begin
                    if (fall) begin
                        sr    <= {d, sr[10:1]};
                        tcnt  <= '0;
                        state <= (n == 4'd0) ? CHECK : DATA;
                        n     <= (n == 4'd0) ? n : n - 4'd1;
                    end else if (tcnt == T_LAST) begin
                        to_r  <= 1'b1;
                        state <= IDLE;
                    end else begin
                        tcnt <= tcnt + 1'b1;
                    end
                end
                CHECK: begin
                    par_r <= ~p;
                    frm_r <= p & ~(sr[10] & ~sr[0]);
                    rx_r  <= push;
                    ovf_r <= good & ~push;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clk_nexys or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count   <= '0;
            empty_r <= 1'b1;
            full_r  <= 1'b0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= sr[8:1];
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (pop) rd_ptr <= rd_ptr + 1'b1;
            count   <= cnt_next;
            empty_r <= cnt_next == '0;
            full_r  <= cnt_next == CNT_FULL;
        end
    end

    assign bus.dato         = mem[rd_ptr];
    assign bus.fifo_empty   = empty_r;
    assign bus.fifo_full    = full_r;
    assign bus.fifo_count   = count;
    assign bus.rx_done_tick = rx_r;
    assign bus.parity_err   = par_r;
    assign bus.frame_err    = frm_r;
    assign bus.timeout_err  = to_r;
    assign bus.overflow     = ovf_r;
endmodule

// File: tb/tb_ps2_rx_fifo.sv
// tb_ps2_rx_fifo: scoreboard bench for ps2_rx_fifo with directed and random PS/2 frames.
module tb_ps2_rx_fifo;
    localparam int FL = 8, TO = 150, AW = 2, DEPTH = 4, HALF = 16;
    localparam logic [4:0] K_RX = 5'b00001, K_PAR = 5'b00010, K_FRM = 5'b00100,
                           K_TO = 5'b01000, K_OVF = 5'b10000;

    typedef struct {
        logic [4:0] kind;
        int         cnt;
    } ev_t;

    logic clk_nexys = 1'b0;
    logic reset = 1'b1;
    ps2_rx_fifo_if #(.FIFO_AW(AW)) bus ();
    ps2_rx_fifo #(.FILTER_LEN(FL), .TIMEOUT_CYC(TO), .FIFO_AW(AW)) dut (
        .clk_nexys(clk_nexys),
        .reset(reset),
        .bus(bus)
    );

    always #5 clk_nexys = ~clk_nexys;

    ev_t        exp_q [$];
    logic [7:0] ref_q [$];
    logic [7:0] dq [$];
    int         checks = 0, errors = 0;
    logic [4:0] mk;
    ev_t        me;

    task automatic chk(string name, logic [31:0] act, logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    task automatic tick(int k = 1);
        repeat (k) @(posedge clk_nexys);
        #1;
    endtask

    task automatic push_ev(logic [4:0] kind, int cnt);
        ev_t e;
        e.kind = kind;
        e.cnt  = cnt;
        exp_q.push_back(e);
    endtask

    task automatic send_bits(logic [10:0] f, int nb);
        for (int i = 0; i < nb; i++) begin
            bus.ps2d = f[i];
            tick(HALF);
            bus.ps2c = 1'b0;
            tick(HALF);
            bus.ps2c = 1'b1;
        end
    endtask

    // Reference: odd parity, parity error wins over stop error, good bytes queue until full.
    task automatic frame(logic [7:0] d, bit bad_par, bit stop);
        logic par;
        par = (~^d) ^ bad_par;
        if (bad_par) push_ev(K_PAR, ref_q.size());
        else if (!stop) push_ev(K_FRM, ref_q.size());
        else if (ref_q.size() < DEPTH) begin
            ref_q.push_back(d);
            push_ev(K_RX, ref_q.size());
        end else push_ev(K_OVF, ref_q.size());
        send_bits({stop, par, d, 1'b0}, 11);
        tick(30);
    endtask

    task automatic timeout_frame(logic [7:0] d, int nb);
        push_ev(K_TO, ref_q.size());
        send_bits({2'b11, d, 1'b0}, nb);
        tick(TO + 30);
    endtask

    task automatic pop_one();
        if (ref_q.size() > 0) dq.push_back(ref_q.pop_front());
        bus.rd_en = 1'b1;
        tick();
        bus.rd_en = 1'b0;
    endtask

    task automatic check_state(string name);
        chk({name, "_count"}, 32'(bus.fifo_count), ref_q.size());
        chk({name, "_empty"}, 32'(bus.fifo_empty), 32'(ref_q.size() == 0));
        chk({name, "_full"}, 32'(bus.fifo_full), 32'(ref_q.size() == DEPTH));
        if (ref_q.size() > 0) chk({name, "_dato"}, 32'(bus.dato), 32'(ref_q[0]));
    endtask

    task automatic check_reset(string name);
        chk({name, "_dato"}, 32'(bus.dato), 0);
        chk({name, "_flags"}, {30'd0, bus.fifo_empty, bus.fifo_full}, 32'b10);
        chk({name, "_count"}, 32'(bus.fifo_count), 0);
        chk({name, "_pulses"}, 32'({bus.overflow, bus.timeout_err, bus.frame_err,
                                    bus.parity_err, bus.rx_done_tick}), 0);
    endtask

    always @(negedge clk_nexys) begin
        if (!reset) begin
            mk = {bus.overflow, bus.timeout_err, bus.frame_err, bus.parity_err, bus.rx_done_tick};
            if (mk != 5'd0) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_pulse actual=%b required=none", mk);
                end else begin
                    me = exp_q.pop_front();
                    chk("pulse_kind", 32'(mk), 32'(me.kind));
                    chk("pulse_count", 32'(bus.fifo_count), me.cnt);
                end
            end
            if (bus.rd_en && !bus.fifo_empty) begin
                if (dq.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_pop actual=%0h required=no_data", bus.dato);
                end else chk("pop_dato", 32'(bus.dato), 32'(dq.pop_front()));
            end
        end
    end

    initial begin
        #900000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] rd;
        int r;
        bus.ps2c  = 1'b1;
        bus.ps2d  = 1'b1;
        bus.rd_en = 1'b0;
        reset     = 1'b1;
        tick(3);
        check_reset("reset");
        reset = 1'b0;
        tick(20);
        frame(8'h1C, 0, 1);
        check_state("single");
        pop_one();
        check_state("single_pop");
        frame(8'hF0, 0, 1);
        frame(8'h1C, 0, 1);
        check_state("two");
        pop_one();
        check_state("two_pop");
        pop_one();
        frame(8'h1C, 1, 1);
        check_state("parity");
        frame(8'h1C, 0, 0);
        check_state("stop");
        frame(8'h1C, 1, 0);
        check_state("priority");
        timeout_frame(8'h1C, 5);
        check_state("timeout");
        frame(8'h5A, 0, 1);
        check_state("after_timeout");
        pop_one();
        for (int i = 1; i <= 5; i++) begin
            frame(8'(i), 0, 1);
            check_state("fill");
        end
        for (int i = 0; i < 4; i++) begin
            pop_one();
            check_state("drain");
        end
        pop_one();
        check_state("pop_empty");
        bus.ps2d = 1'b0;
        repeat (5) begin
            bus.ps2c = 1'b0;
            tick(FL - 1);
            bus.ps2c = 1'b1;
            tick(FL + 2);
        end
        tick(TO + 20);
        check_state("glitch");
        frame(8'h33, 0, 1);
        check_state("after_glitch");
        pop_one();
        send_bits({3'b110, 8'h1C}, 4);
        reset = 1'b1;
        #1;
        check_reset("midframe_reset");
        tick(3);
        ref_q.delete();
        dq.delete();
        exp_q.delete();
        reset    = 1'b0;
        bus.ps2d = 1'b1;
        tick(20);
        frame(8'h1C, 0, 1);
        check_state("after_reset");
        pop_one();
        repeat (40) begin
            rd = 8'($urandom);
            r  = $urandom_range(0, 9);
            if (r == 2) timeout_frame(rd, $urandom_range(1, 10));
            else frame(rd, r == 0, r != 1);
            check_state("rand_frame");
            repeat ($urandom_range(0, 2)) begin
                pop_one();
                check_state("rand_pop");
            end
        end
        for (int i = 0; i < 2000 && exp_q.size() != 0; i++) tick();
        chk("events_drained", exp_q.size(), 0);
        chk("pops_drained", dq.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
